soc_system_hps_fifo_write_arbiter: RTL

Round-robin arbiter that shares the single byte-wide write port of the HPS-bound FIFO among several fabric requesters. It gates every transfer on the FIFO's write-full flag and bounds each grant to a fixed burst length. An Avalon-MM control/status slave lets HPS software enable the arbiter, read live status, count transfers, and take a sticky, interrupt-capable record of full events.

---
 rtl/soc_system_hps_fifo_write_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/soc_system_hps_fifo_write_arbiter.sv
// soc_system_hps_fifo_write_arbiter: round-robin arbiter onto one FIFO write port, with an Avalon-MM control/status slave
module soc_system_hps_fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wrreq,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic                      fifo_wrfull,
  input  logic [1:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [1:0] grant, grant_nxt, last_grant, last_nxt, pick, idx;
  logic [3:0] burst_cnt, burst_nxt;
  logic enable, irq_en, wrfull_q, found, xfer, stall, wr_en, open;
  logic [15:0] xfer_cnt;
  logic [1:0] events;
  logic [31:0] status, rd_mux;
  logic [DATA_W-1:0] lane [NUM_REQ];
  logic unused_wd;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DATA_W +: DATA_W];
  end
  assign unused_wd = ^writedata[31:2];
  assign open = state == GRANT && enable && !fifo_wrfull;
  assign req_ready = open ? NUM_REQ'(1) << grant : '0;
  assign xfer = open && req_valid[grant];
  assign fifo_wrreq = xfer;
  assign fifo_data = lane[grant];
  assign stall = state == GRANT && req_valid[grant] && fifo_wrfull;
  assign wr_en = chipselect && !write_n;
  // Scan from farthest to nearest so the nearest valid requester after last_grant wins.
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = 2'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt = last_grant;
    burst_nxt = burst_cnt;
    if (state == IDLE) begin
      if (enable && found) begin
        state_nxt = GRANT;
        grant_nxt = pick;
        burst_nxt = '0;
      end
    end else begin
      if (xfer) burst_nxt = burst_cnt + 4'd1;
      if ((xfer && burst_cnt == 4'(MAX_BURST-1)) || !req_valid[grant] || !enable) begin
        state_nxt = IDLE;
        last_nxt = grant;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= 2'(NUM_REQ-1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last_grant <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  always_comb begin
    status = '0;
    status[NUM_REQ-1:0] = req_valid;
    status[8] = fifo_wrfull;
    status[11:10] = grant;
    status[12] = state == GRANT;
  end
  assign rd_mux = address == 2'd0 ? {30'b0, irq_en, enable} :
                  address == 2'd1 ? status :
                  address == 2'd2 ? {16'b0, xfer_cnt} : {30'b0, events};
  // Software clears take priority over same-cycle hardware updates.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      xfer_cnt <= '0;
      events <= '0;
      wrfull_q <= 1'b0;
      irq <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_en && address == 2'd0) {irq_en, enable} <= writedata[1:0];
      xfer_cnt <= (wr_en && address == 2'd2) ? '0 : xfer ? xfer_cnt + 16'd1 : xfer_cnt;
      events <= (wr_en && address == 2'd3) ? '0 : events | {stall, fifo_wrfull & ~wrfull_q};
      wrfull_q <= fifo_wrfull;
      irq <= irq_en & |events;
      readdata <= rd_mux;
    end
endmodule
